i2c_master_ctrl: RTL and testbench

- Single-byte I2C master controller that generates SCL and drives open-drain SDA toward the i2c_slave_top block.
- Runs one complete transaction per request: START, 7-bit address, R/W bit, slave ACK, one data byte, ACK/NACK, STOP.
- A register-level host drives it in the FPGA fabric.
- It also serves as the stimulus source for system-level slave testing.

---
 rtl/i2c_master_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain (only ever driven low).
module i2c_master_ctrl #(
  parameter int unsigned DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_WDATA,
    S_ACK2W, S_RDATA, S_ACK2R, S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    shift_q, shift_d;
  logic          smp_q, smp_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aerr_q, aerr_d;

  logic       q_wrap, slot_end, smp_now, accept;
  logic       sda_in, sda_oe, scl_o;
  logic [7:0] abyte;

  assign sda_in   = SDA;
  assign q_wrap   = (qcnt_q == QMAX);
  assign slot_end = q_wrap && (ph_q == 2'd3);
  assign smp_now  = q_wrap && (ph_q == 2'd2);
  // A req coinciding with the done pulse must not start a new transfer
  assign accept   = (state_q == S_IDLE) && req && !done_q;
  assign abyte    = {addr_q, rw_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      shift_q <= '0;
      smp_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      smp_q   <= smp_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aerr_q  <= aerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    aerr_d  = aerr_q;

    if (state_q != S_IDLE) begin
      qcnt_d = q_wrap ? '0 : qcnt_q + 1'b1;
      if (q_wrap) ph_d = ph_q + 2'd1;
      if (smp_now) begin
        smp_d = sda_in;
        if (state_q == S_RDATA) shift_d = {shift_q[6:0], sda_in};
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = wdata;
          busy_d  = 1'b1;
          aerr_d  = 1'b0;
          qcnt_d  = '0;
          ph_d    = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (slot_end) begin
          bit_d   = 3'd7;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (slot_end) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = S_ACK1;
        end
      end
      S_ACK1: begin
        if (slot_end) begin
          bit_d = 3'd7;
          if (smp_q) begin
            aerr_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = rw_q ? S_RDATA : S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (slot_end) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = S_ACK2W;
        end
      end
      S_ACK2W: begin
        if (slot_end) begin
          if (smp_q) aerr_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_RDATA: begin
        if (slot_end) begin
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) begin
            rdata_d = shift_q;
            state_d = S_ACK2R;
          end
        end
      end
      S_ACK2R: begin
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (slot_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sda_oe = 1'b0;
    scl_o  = ph_q[1];
    unique case (state_q)
      S_IDLE:  scl_o = 1'b1;
      S_START: begin
        scl_o  = 1'b1;
        sda_oe = ph_q[1];
      end
      S_ADDR:  sda_oe = ~abyte[bit_q];
      S_WDATA: sda_oe = ~wdata_q[bit_q];
      S_STOP: begin
        scl_o  = (ph_q != 2'd0);
        sda_oe = (ph_q != 2'd3);
      end
      default: sda_oe = 1'b0;
    endcase
  end

  assign SDA     = sda_oe ? 1'b0 : 1'bz;
  assign SCL     = scl_o;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = aerr_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl with a behavioural slave at address 7'h2A.
// Vector table for whole transactions plus reset and ignored-req sequences.
module tb_i2c_master_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic       req;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       scl;
  wire        sda;

  int checks = 0;
  int errors = 0;

  i2c_master_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .rw(rw),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .SCL(scl), .SDA(sda)
  );

  pullup (sda);

  logic       s_oe;
  assign sda = s_oe ? 1'b0 : 1'bz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural slave plus bus monitor, evaluated away from the DUT edge
  logic        s_present;
  logic        s_act, s_sel, s_rw;
  logic        s_scl_p, s_sda_p;
  int          s_cnt;
  logic [7:0]  s_sh, s_wb, s_mem;
  logic [7:0]  s_rbyte;
  logic [17:0] pr;
  int          n_fall, n_rise, n_done;

  always @(negedge clk) begin
    if (!reset) begin
      s_act   <= 1'b0;
      s_sel   <= 1'b0;
      s_oe    <= 1'b0;
      s_cnt   <= 0;
      s_scl_p <= 1'b1;
      s_sda_p <= 1'b1;
    end else begin
      if (done) n_done <= n_done + 1;
      if (scl && s_scl_p && s_sda_p && !sda) begin
        s_act  <= 1'b1;
        s_sel  <= 1'b0;
        s_cnt  <= 0;
        s_oe   <= 1'b0;
        n_fall <= n_fall + 1;
      end else if (scl && s_scl_p && !s_sda_p && sda) begin
        s_act  <= 1'b0;
        s_oe   <= 1'b0;
        n_rise <= n_rise + 1;
      end else if (s_act && scl && !s_scl_p) begin
        if (s_cnt < 18) pr[s_cnt] <= sda;
        if (s_cnt < 8) s_sh <= {s_sh[6:0], sda};
        if (s_cnt >= 9 && s_cnt <= 16) s_wb <= {s_wb[6:0], sda};
        s_cnt <= s_cnt + 1;
      end else if (s_act && !scl && s_scl_p) begin
        if (s_cnt == 8) begin
          s_rw  <= s_sh[0];
          s_sel <= s_present && (s_sh[7:1] == 7'h2A);
          s_oe  <= s_present && (s_sh[7:1] == 7'h2A);
        end else if (s_cnt >= 9 && s_cnt <= 16) begin
          s_oe <= s_sel && s_rw && !s_rbyte[16 - s_cnt];
        end else if (s_cnt == 17) begin
          s_oe <= s_sel && !s_rw;
          if (s_sel && !s_rw) s_mem <= s_wb;
        end else begin
          s_oe <= 1'b0;
        end
      end
      s_scl_p <= scl;
      s_sda_p <= sda;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_txn(input logic [6:0] a, input logic r,
                           input logic [7:0] w);
    @(negedge clk);
    addr  = a;
    rw    = r;
    wdata = w;
    req   = 1'b1;
    @(negedge clk);
    req   = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
    end
  endtask

  function automatic logic [7:0] pbyte(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = pr[base+i];
    return b;
  endfunction

  typedef struct {
    logic [6:0] a;
    logic       rw;
    logic [7:0] wd;
    logic       pres;
    int         cyc;
    logic       aerr;
    logic [7:0] rd;
    logic [7:0] ab;
    logic       full;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc;
    int dbase;

    vecs[0] = '{7'h2A, 1'b0, 8'hA5, 1'b1, 320, 1'b0, 8'h00, 8'h54, 1'b1};
    vecs[1] = '{7'h2A, 1'b1, 8'h00, 1'b1, 320, 1'b0, 8'h3C, 8'h55, 1'b1};
    vecs[2] = '{7'h11, 1'b0, 8'hFF, 1'b1, 176, 1'b1, 8'h3C, 8'h22, 1'b0};
    vecs[3] = '{7'h2A, 1'b0, 8'h5A, 1'b1, 320, 1'b0, 8'h3C, 8'h54, 1'b1};
    vecs[4] = '{7'h2A, 1'b1, 8'h00, 1'b0, 176, 1'b1, 8'h3C, 8'h55, 1'b0};

    reset     = 1'b0;
    req       = 1'b0;
    addr      = '0;
    rw        = 1'b0;
    wdata     = '0;
    s_present = 1'b1;
    s_rbyte   = 8'h3C;
    s_mem     = '0;
    s_sh      = '0;
    s_wb      = '0;
    s_rw      = 1'b0;
    pr        = '1;
    n_fall    = 0;
    n_rise    = 0;
    n_done    = 0;

    repeat (3) @(negedge clk);
    chk("reset_scl", 32'(scl), 32'd1);
    chk("reset_sda", 32'(sda), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ackerr", 32'(ack_err), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      s_present = vecs[v].pres;
      pr        = '1;
      n_fall    = 0;
      n_rise    = 0;
      start_txn(vecs[v].a, vecs[v].rw, vecs[v].wd);
      chk($sformatf("v%0d_busy_start", v), 32'(busy), 32'd1);
      wait_done(cyc);
      chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].cyc));
      chk($sformatf("v%0d_ackerr", v), 32'(ack_err), 32'(vecs[v].aerr));
      chk($sformatf("v%0d_rdata", v), 32'(rdata), 32'(vecs[v].rd));
      chk($sformatf("v%0d_busy_done", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_addr_bits", v), 32'(pbyte(0)), 32'(vecs[v].ab));
      chk($sformatf("v%0d_start_cnt", v), 32'(n_fall), 32'd1);
      chk($sformatf("v%0d_stop_cnt", v), 32'(n_rise), 32'd1);
      if (vecs[v].full) begin
        dbase = 9;
        if (!vecs[v].rw) begin
          chk($sformatf("v%0d_data_bits", v), 32'(pbyte(dbase)),
              32'(vecs[v].wd));
          chk($sformatf("v%0d_slave_mem", v), 32'(s_mem), 32'(vecs[v].wd));
        end else begin
          chk($sformatf("v%0d_master_nack", v), 32'(pr[17]), 32'd1);
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
      repeat (5) @(negedge clk);
    end

    // Requests while busy and in the done cycle are both ignored
    s_present = 1'b1;
    pr        = '1;
    n_done    = 0;
    start_txn(7'h2A, 1'b0, 8'h77);
    repeat (100) @(negedge clk);
    addr  = 7'h55;
    rw    = 1'b1;
    wdata = 8'h00;
    req   = 1'b1;
    @(negedge clk);
    req   = 1'b0;
    wait_done(cyc);
    addr = 7'h11;
    req  = 1'b1;
    @(negedge clk);
    req  = 1'b0;
    chk("ign_busy_after_done", 32'(busy), 32'd0);
    repeat (400) @(negedge clk);
    chk("ign_done_count", 32'(n_done), 32'd1);
    chk("ign_addr_bits", 32'(pbyte(0)), 32'h54);
    chk("ign_slave_mem", 32'(s_mem), 32'h77);
    chk("ign_ackerr", 32'(ack_err), 32'd0);

    // Reset asserted while the address is being shifted out
    n_done = 0;
    start_txn(7'h2A, 1'b0, 8'hC3);
    repeat (40) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(scl), 32'd1);
    chk("mid_rst_sda", 32'(sda), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    chk("mid_rst_no_done", 32'(n_done), 32'd0);
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);
    chk("mid_rst_idle_scl", 32'(scl), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
